// File: rtl/enigma_uart_tx.sv
// Enigma cipher-letter UART transmitter: 5-bit letter codes in, 8N1 ASCII frames out.
// Define ENIGMA_TX_GROUP_EN to insert a space after every GROUP_LEN letters.
module enigma_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int GROUP_LEN    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] letter_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       err_o
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t         state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic [4:0]     hold_q, hold_d;
   logic           hold_full_q, hold_full_d;
   logic           tx_q, tx_d;
   logic           err_q, err_d;
   logic           baud_last;
   logic           launch;
   logic           deq;

`ifdef ENIGMA_TX_GROUP_EN
   localparam int GW = $clog2(GROUP_LEN + 1);
   localparam logic [GW-1:0] GRP_MAX = GW'(GROUP_LEN);
   logic [GW-1:0]  grp_q, grp_d;
`endif

   function automatic logic [7:0] to_ascii(input logic [4:0] code);
      return 8'h41 + {3'b000, code};
   endfunction

   assign baud_last = (baud_q == BAUD_LAST);
   assign ready_o   = ~hold_full_q;
   assign busy_o    = (state_q != S_IDLE) | hold_full_q;
   assign tx_o      = tx_q;
   assign err_o     = err_q;

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = tx_q;
      err_d       = 1'b0;
      launch      = 1'b0;
      deq         = 1'b0;
`ifdef ENIGMA_TX_GROUP_EN
      grp_d       = grp_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            tx_d   = 1'b1;
            launch = hold_full_q;
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (hold_full_q) launch = 1'b1;
               else             state_d = S_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A launch starts the next frame directly, so STOP->START has no idle gap.
      if (launch) begin
         state_d = S_START;
         tx_d    = 1'b0;
`ifdef ENIGMA_TX_GROUP_EN
         if (grp_q == GRP_MAX) begin
            shift_d = 8'h20;
            grp_d   = '0;
         end else begin
            shift_d = to_ascii(hold_q);
            deq     = 1'b1;
            grp_d   = grp_q + 1'b1;
         end
`else
         shift_d = to_ascii(hold_q);
         deq     = 1'b1;
`endif
      end

      if (deq) hold_full_d = 1'b0;

      // Out-of-range codes complete the handshake but are discarded.
      if (valid_i && ready_o) begin
         if (letter_i < 5'd26) begin
            hold_d      = letter_i;
            hold_full_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         err_q       <= 1'b0;
`ifdef ENIGMA_TX_GROUP_EN
         grp_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         err_q       <= err_d;
`ifdef ENIGMA_TX_GROUP_EN
         grp_q       <= grp_d;
`endif
      end
   end

endmodule

// File: tb/tb_enigma_uart_tx.sv
// Bench for enigma_uart_tx: line-level UART receiver monitor plus a letter-stream reference model.
module tb_enigma_uart_tx;

   localparam int CPB       = 4;
   localparam int GROUP_LEN = 5;
   localparam int FRAME     = 10 * CPB;

   logic       clk;
   logic       rst_n;
   logic [4:0] letter_i;
   logic       valid_i;
   logic       ready_o;
   logic       tx_o;
   logic       busy_o;
   logic       err_o;

   int compared = 0;
   int fails    = 0;

   enigma_uart_tx #(.CLKS_PER_BIT(CPB), .GROUP_LEN(GROUP_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .letter_i(letter_i), .valid_i(valid_i),
      .ready_o(ready_o), .tx_o(tx_o), .busy_o(busy_o), .err_o(err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Receiver monitor: decodes frames from the line, checks every bit is held CPB cycles.
   int         negcnt    = 0;
   int         mcyc      = -1;
   int         fstart    = 0;
   int         frame_err = 0;
   int         rdy_low   = 0;
   int         busy_cnt  = 0;
   int         err_cnt   = 0;
   int         err_at    = 0;
   logic [9:0] bitv;
   logic [7:0] rx_q[$];
   int         rx_t[$];

   always @(negedge clk) begin
      negcnt++;
      if (!ready_o) rdy_low++;
      if (busy_o)   busy_cnt++;
      if (err_o) begin
         err_cnt++;
         err_at = negcnt;
      end
      if (!rst_n) begin
         mcyc = -1;
      end else begin
         if (mcyc < 0 && tx_o == 1'b0) begin
            mcyc   = 0;
            fstart = negcnt;
         end
         if (mcyc >= 0) begin
            if (mcyc % CPB == 0) bitv[mcyc / CPB] = tx_o;
            else if (tx_o !== bitv[mcyc / CPB]) frame_err++;
            mcyc++;
            if (mcyc == FRAME) begin
               if (bitv[0] !== 1'b0 || bitv[9] !== 1'b1) frame_err++;
               rx_q.push_back(bitv[8:1]);
               rx_t.push_back(fstart);
               mcyc = -1;
            end
         end
      end
   end

   // Reference model: expected byte stream from the sequence of offered letters.
   logic [7:0] exp_q[$];
   int         nsent = 0;

   function automatic void model_letter(input logic [4:0] l);
      if (l < 5'd26) begin
`ifdef ENIGMA_TX_GROUP_EN
         if (nsent > 0 && nsent % GROUP_LEN == 0) exp_q.push_back(8'h20);
`endif
         exp_q.push_back(8'h41 + {3'b000, l});
         nsent++;
      end
   endfunction

   function automatic void clear_logs();
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
      frame_err = 0;
   endfunction

   // Called at negedge+1; returns the negedge index at which acceptance was decided.
   task automatic send(input logic [4:0] l, output int acc);
      int n;
      n        = 0;
      letter_i = l;
      valid_i  = 1'b1;
      while (!ready_o && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 2000) begin
         compared++; fails++;
         $display("FAIL send_timeout: ready_o never rose for letter %0d", l);
      end
      acc = negcnt;
      model_letter(l);
      @(negedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while ((busy_o || mcyc >= 0) && n < 5000);
      if (n >= 5000) begin
         compared++; fails++;
         $display("FAIL %s_idle_timeout: busy_o=%b after %0d cycles, need 0", tag, busy_o, n);
      end
      repeat (2) begin @(negedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) begin @(negedge clk); #1; end
      rst_n = 1'b1;
      nsent = 0;
      clear_logs();
   endtask

   task automatic test_reset();
      int a;
      rst_n = 1'b0; valid_i = 1'b0; letter_i = '0;
      repeat (3) begin @(negedge clk); #1; end
      compared++; if (tx_o !== 1'b1)    begin fails++; $display("FAIL reset_tx: got %b need 1", tx_o); end
      compared++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b need 1", ready_o); end
      compared++; if (busy_o !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b need 0", busy_o); end
      compared++; if (err_o !== 1'b0)   begin fails++; $display("FAIL reset_err: got %b need 0", err_o); end
      rst_n = 1'b1;
      @(negedge clk); #1;
      send(5'd3, a);
      repeat (12) begin @(negedge clk); #1; end
      compared++; if (busy_o !== 1'b1)  begin fails++; $display("FAIL midframe_busy: got %b need 1", busy_o); end
      rst_n = 1'b0;
      #1;
      compared++; if (tx_o !== 1'b1)    begin fails++; $display("FAIL abort_tx: got %b need 1", tx_o); end
      compared++; if (ready_o !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b need 1", ready_o); end
      compared++; if (busy_o !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b need 0", busy_o); end
      @(negedge clk); #1;
      rst_n = 1'b1;
      nsent = 0;
      repeat (60) begin @(negedge clk); #1; end
      compared++; if (rx_q.size() != 0) begin fails++; $display("FAIL abort_residual: got %0d frames need 0", rx_q.size()); end
      compared++; if (tx_o !== 1'b1)    begin fails++; $display("FAIL abort_line: got %b need 1", tx_o); end
      clear_logs();
   endtask

   task automatic test_single();
      int a;
      clear_logs();
      send(5'd0, a);
      wait_idle("single");
      compared++; if (rx_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d frames need 1", rx_q.size()); end
      else begin
         compared++; if (rx_q[0] !== exp_q[0]) begin fails++; $display("FAIL single_byte: got %h need %h", rx_q[0], exp_q[0]); end
         compared++; if (rx_q[0] !== 8'h41)    begin fails++; $display("FAIL single_ascii: got %h need 41", rx_q[0]); end
         compared++; if (rx_t[0] != a + 2)     begin fails++; $display("FAIL single_latency: start at %0d need %0d", rx_t[0], a + 2); end
      end
      compared++; if (frame_err != 0) begin fails++; $display("FAIL single_timing: got %0d framing errors need 0", frame_err); end
   endtask

   task automatic test_back_to_back();
      int a1, a2;
      clear_logs();
      rdy_low = 0;
      send(5'd25, a1);
      send(5'd12, a2);
      wait_idle("b2b");
      compared++; if (rx_q.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d frames need 2", rx_q.size()); end
      else begin
         compared++; if (rx_q[0] !== 8'h5A) begin fails++; $display("FAIL b2b_byte0: got %h need 5a", rx_q[0]); end
         compared++; if (rx_q[1] !== 8'h4D) begin fails++; $display("FAIL b2b_byte1: got %h need 4d", rx_q[1]); end
         compared++; if (rx_t[1] != rx_t[0] + FRAME) begin fails++; $display("FAIL b2b_gap: second start %0d need %0d", rx_t[1], rx_t[0] + FRAME); end
      end
      compared++; if (rdy_low != FRAME) begin fails++; $display("FAIL b2b_ready_low: got %0d cycles need %0d", rdy_low, FRAME); end
      compared++; if (frame_err != 0) begin fails++; $display("FAIL b2b_timing: got %0d framing errors need 0", frame_err); end
   endtask

   task automatic test_invalid();
      int a, b;
      clear_logs();
      err_cnt = 0; busy_cnt = 0;
      send(5'd26, a);
      repeat (4) begin @(negedge clk); #1; end
      compared++; if (err_cnt != 1)  begin fails++; $display("FAIL inv_err_pulses: got %0d need 1", err_cnt); end
      compared++; if (err_at != a + 1) begin fails++; $display("FAIL inv_err_time: at %0d need %0d", err_at, a + 1); end
      send(5'd31, b);
      repeat (10) begin @(negedge clk); #1; end
      compared++; if (err_cnt != 2)  begin fails++; $display("FAIL inv_err_pulses2: got %0d need 2", err_cnt); end
      compared++; if (busy_cnt != 0) begin fails++; $display("FAIL inv_busy: got %0d busy cycles need 0", busy_cnt); end
      compared++; if (rx_q.size() != 0 || mcyc >= 0) begin fails++; $display("FAIL inv_line: got %0d frames need 0", rx_q.size()); end
      compared++; if (ready_o !== 1'b1) begin fails++; $display("FAIL inv_ready: got %b need 1", ready_o); end
   endtask

   task automatic test_random();
      int a;
      clear_logs();
      for (int i = 0; i < 12; i++) send(5'($urandom_range(0, 25)), a);
      wait_idle("random");
      compared++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d frames need %0d", rx_q.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            compared++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_byte%0d: got %h need %h", i, rx_q[i], exp_q[i]); end
         end
         for (int i = 1; i < rx_t.size(); i++) begin
            compared++; if (rx_t[i] != rx_t[i-1] + FRAME) begin fails++; $display("FAIL rand_gap%0d: start %0d need %0d", i, rx_t[i], rx_t[i-1] + FRAME); end
         end
      end
      compared++; if (frame_err != 0) begin fails++; $display("FAIL rand_timing: got %0d framing errors need 0", frame_err); end
   endtask

   task automatic test_group();
      int a, last;
      logic [7:0] want[$];
`ifdef ENIGMA_TX_GROUP_EN
      want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47};
`else
      want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
`endif
      do_reset();
      for (int i = 0; i < 7; i++) send(5'(i), a);
      wait_idle("group");
      compared++; if (rx_q.size() != want.size()) begin fails++; $display("FAIL grp_count: got %0d frames need %0d", rx_q.size(), want.size()); end
      else begin
         for (int i = 0; i < want.size(); i++) begin
            compared++; if (rx_q[i] !== want[i]) begin fails++; $display("FAIL grp_byte%0d: got %h need %h", i, rx_q[i], want[i]); end
         end
         last = rx_t[rx_t.size() - 1] + FRAME - rx_t[0];
         compared++; if (last != want.size() * FRAME) begin fails++; $display("FAIL grp_span: got %0d cycles need %0d", last, want.size() * FRAME); end
      end
      compared++; if (frame_err != 0) begin fails++; $display("FAIL grp_timing: got %0d framing errors need 0", frame_err); end
   endtask

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; letter_i = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_invalid();
      test_random();
      test_group();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
      $finish;
   end

endmodule
